// File: rtl/asg_sweep_ctrl.sv
// Frequency-sweep sequencer for one ASG channel.
// Drives the channel step input with a timed linear ramp in one-shot, sawtooth or triangle mode.
module asg_sweep_ctrl #(
  parameter int unsigned RSZ      = 14,
  parameter int unsigned TICK_DIV = 125
) (
  input  logic            dac_clk_i,
  input  logic            dac_rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [RSZ+15:0] cfg_start_i,
  input  logic [RSZ+15:0] cfg_stop_i,
  input  logic [RSZ+15:0] cfg_inc_i,
  input  logic [31:0]     cfg_period_i,
  input  logic [1:0]      cfg_mode_i,
  input  logic [15:0]     cfg_loops_i,
  output logic [RSZ+15:0] step_o,
  output logic            step_vld_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            dir_o,
  output logic [15:0]     loop_cnt_o
);

  localparam int unsigned SW = RSZ + 16;
  localparam int unsigned EW = SW + 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            vld_q, vld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            dir_q, dir_d;
  logic            wrap_q, wrap_d;
  logic [15:0]     loop_q, loop_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [31:0]     pcnt_q, pcnt_d;
  logic [SW-1:0]   sh_start_q, sh_start_d;
  logic [SW-1:0]   sh_stop_q, sh_stop_d;
  logic [SW-1:0]   sh_inc_q, sh_inc_d;
  logic [31:0]     sh_period_q, sh_period_d;
  logic [1:0]      sh_mode_q, sh_mode_d;
  logic [15:0]     sh_loops_q, sh_loops_d;

  logic [EW-1:0]   nxt_up_c, nxt_dn_c;
  logic            top_c, bot_c, tick_c, upd_c, last_c;
  logic [15:0]     loop_inc_c;

  // Ramp arithmetic carried one bit wider so neither direction can wrap.
  always_comb begin
    nxt_up_c   = {1'b0, step_q} + {1'b0, sh_inc_q};
    nxt_dn_c   = {1'b0, step_q} - {1'b0, sh_inc_q};
    top_c      = nxt_up_c >= {1'b0, sh_stop_q};
    bot_c      = nxt_dn_c[SW] || (nxt_dn_c <= {1'b0, sh_start_q});
    loop_inc_c = (loop_q == 16'hFFFF) ? loop_q : loop_q + 16'd1;
    last_c     = (sh_loops_q != 16'd0) && (loop_inc_c == sh_loops_q);
    tick_c     = presc_q == PW'(TICK_DIV - 1);
    upd_c      = tick_c && (pcnt_q == sh_period_q - 32'd1);
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    vld_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    dir_d       = dir_q;
    wrap_d      = wrap_q;
    loop_d      = loop_q;
    presc_d     = presc_q;
    pcnt_d      = pcnt_q;
    sh_start_d  = sh_start_q;
    sh_stop_d   = sh_stop_q;
    sh_inc_d    = sh_inc_q;
    sh_period_d = sh_period_q;
    sh_mode_d   = sh_mode_q;
    sh_loops_d  = sh_loops_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if ((cfg_inc_i == '0) || (cfg_start_i > cfg_stop_i)) begin
            err_d = 1'b1;
          end else begin
            sh_start_d  = cfg_start_i;
            sh_stop_d   = cfg_stop_i;
            sh_inc_d    = cfg_inc_i;
            sh_period_d = (cfg_period_i == 32'd0) ? 32'd1 : cfg_period_i;
            sh_mode_d   = (cfg_mode_i == 2'd3) ? 2'd0 : cfg_mode_i;
            sh_loops_d  = cfg_loops_i;
            step_d      = cfg_start_i;
            vld_d       = 1'b1;
            busy_d      = 1'b1;
            dir_d       = 1'b1;
            wrap_d      = 1'b0;
            loop_d      = 16'd0;
            presc_d     = '0;
            pcnt_d      = 32'd0;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (tick_c) pcnt_d = upd_c ? 32'd0 : pcnt_q + 32'd1;
        if (stop_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (upd_c) begin
          vld_d = 1'b1;
          if (wrap_q) begin
            step_d = sh_start_q;
            wrap_d = 1'b0;
          end else if (dir_q) begin
            if (top_c) begin
              step_d = sh_stop_q;
              unique case (sh_mode_q)
                2'd1: begin
                  loop_d = loop_inc_c;
                  if (last_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                  end else begin
                    wrap_d = 1'b1;
                  end
                end
                2'd2:    dir_d = 1'b0;
                default: begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
                end
              endcase
            end else begin
              step_d = nxt_up_c[SW-1:0];
            end
          end else begin
            if (bot_c) begin
              step_d = sh_start_q;
              loop_d = loop_inc_c;
              if (last_c) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
              end else begin
                dir_d = 1'b1;
              end
            end else begin
              step_d = nxt_dn_c[SW-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q     <= IDLE;
      step_q      <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dir_q       <= 1'b1;
      wrap_q      <= 1'b0;
      loop_q      <= 16'd0;
      presc_q     <= '0;
      pcnt_q      <= 32'd0;
      sh_start_q  <= '0;
      sh_stop_q   <= '0;
      sh_inc_q    <= '0;
      sh_period_q <= 32'd1;
      sh_mode_q   <= 2'd0;
      sh_loops_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
      loop_q      <= loop_d;
      presc_q     <= presc_d;
      pcnt_q      <= pcnt_d;
      sh_start_q  <= sh_start_d;
      sh_stop_q   <= sh_stop_d;
      sh_inc_q    <= sh_inc_d;
      sh_period_q <= sh_period_d;
      sh_mode_q   <= sh_mode_d;
      sh_loops_q  <= sh_loops_d;
    end
  end

  assign step_o     = step_q;
  assign step_vld_o = vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign dir_o      = dir_q;
  assign loop_cnt_o = loop_q;

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// Directed bench for asg_sweep_ctrl with a 4-cycle time-base tick.
module tb_asg_sweep_ctrl;

  localparam int unsigned RSZ = 14;
  localparam int unsigned SW  = RSZ + 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop;
  logic [SW-1:0] c_start, c_stop, c_inc;
  logic [31:0]   c_period;
  logic [1:0]    c_mode;
  logic [15:0]   c_loops;
  logic [SW-1:0] step;
  logic          vld, busy, done, err, dir;
  logic [15:0]   loops;

  int checks = 0;
  int errors = 0;

  asg_sweep_ctrl #(.RSZ(RSZ), .TICK_DIV(4)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .start_i(start), .stop_i(stop),
    .cfg_start_i(c_start), .cfg_stop_i(c_stop), .cfg_inc_i(c_inc),
    .cfg_period_i(c_period), .cfg_mode_i(c_mode), .cfg_loops_i(c_loops),
    .step_o(step), .step_vld_o(vld), .busy_o(busy), .done_o(done),
    .err_o(err), .dir_o(dir), .loop_cnt_o(loops)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [SW-1:0] s, input logic [SW-1:0] e, input logic [SW-1:0] inc,
                     input logic [31:0] per, input logic [1:0] mode, input logic [15:0] lp);
    c_start = s; c_stop = e; c_inc = inc; c_period = per; c_mode = mode; c_loops = lp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  logic [SW-1:0] tri_step [8];
  logic          tri_dir  [8];
  logic [15:0]   tri_loop [8];
  logic [SW-1:0] saw_step [7];
  logic [15:0]   saw_loop [7];

  initial begin
    tri_step = '{30'h20000, 30'h30000, 30'h20000, 30'h10000, 30'h20000, 30'h30000, 30'h20000, 30'h10000};
    tri_dir  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tri_loop = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    saw_step = '{30'h20000, 30'h30000, 30'h10000, 30'h20000, 30'h30000, 30'h10000, 30'h20000};
    saw_loop = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg(30'h10000, 30'h40000, 30'h10000, 32'd2, 2'd0, 16'd0);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_step", 64'(step), 64'h0);
    chk("rst_flags", {busy, vld, done, err, dir}, 5'b00001);
    chk("rst_loop", 64'(loops), 64'h0);

    // one-shot, period 2: updates every 8 cycles
    pulse_start();
    chk("os_start_step", 64'(step), 64'h10000);
    chk("os_start_flags", {busy, vld, done, dir}, 4'b1101);
    cyc(7);
    chk("os_gap_vld", 64'(vld), 64'h0);
    cyc(1);
    chk("os_u1", {vld, 30'(step)}, {1'b1, 30'h20000});
    cyc(8);
    chk("os_u2", {vld, 30'(step)}, {1'b1, 30'h30000});
    cyc(8);
    chk("os_u3", {vld, 30'(step)}, {1'b1, 30'h40000});
    chk("os_done", {done, busy}, 2'b10);
    cyc(1);
    chk("os_hold", {done, busy, vld, 30'(step)}, {3'b000, 30'h40000});

    // clamp to a stop value that is not a multiple of inc; period 0 acts as 1
    cfg(30'h10000, 30'h45000, 30'h10000, 32'd0, 2'd0, 16'd0);
    pulse_start();
    for (int k = 2; k <= 4; k++) begin
      cyc(4);
      chk("cl_up", {vld, done, 30'(step)}, {2'b10, 30'(k * 32'h10000)});
    end
    cyc(4);
    chk("cl_clamp", {vld, done, busy, 30'(step)}, {3'b110, 30'h45000});

    // triangle, two loops
    cfg(30'h10000, 30'h30000, 30'h10000, 32'd0, 2'd2, 16'd2);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      cyc(4);
      chk("tri_step", {vld, 30'(step)}, {1'b1, tri_step[k]});
      chk("tri_dir", 64'(dir), 64'(tri_dir[k]));
      chk("tri_loop", 64'(loops), 64'(tri_loop[k]));
      chk("tri_done", {done, busy}, (k == 7) ? 2'b10 : 2'b01);
    end
    cyc(1);
    chk("tri_after", 64'(done), 64'h0);

    // sawtooth, infinite, then abort mid-period
    cfg(30'h10000, 30'h30000, 30'h10000, 32'd0, 2'd1, 16'd0);
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      cyc(4);
      chk("saw_step", {vld, dir, 30'(step)}, {2'b11, saw_step[k]});
      chk("saw_loop", 64'(loops), 64'(saw_loop[k]));
    end
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("abort", {busy, done, vld, 30'(step)}, {3'b000, 30'h20000});
    cyc(6);
    chk("abort_idle", {busy, done, vld, 30'(step)}, {3'b000, 30'h20000});

    // rejected starts
    cfg(30'h30000, 30'h10000, 30'h10000, 32'd0, 2'd0, 16'd0);
    pulse_start();
    chk("err_range", {err, busy, 30'(step)}, {2'b10, 30'h20000});
    cyc(1);
    chk("err_clear", 64'(err), 64'h0);
    cfg(30'h10000, 30'h30000, 30'h0, 32'd0, 2'd0, 16'd0);
    pulse_start();
    chk("err_inc", {err, busy}, 2'b10);
    cfg(30'h10000, 30'h30000, 30'h10000, 32'd0, 2'd0, 16'd0);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("start_stop", {err, busy, vld}, 3'b000);

    // start during RUN is ignored, shadow config unaffected
    cfg(30'h10000, 30'h30000, 30'h10000, 32'd0, 2'd1, 16'd0);
    pulse_start();
    cyc(2);
    c_inc = 30'h0;
    pulse_start();
    chk("run_start", {err, busy}, 2'b01);
    cyc(1);
    chk("run_upd", {vld, 30'(step)}, {1'b1, 30'h20000});
    cyc(4);
    chk("run_top", {30'(step), 16'(loops)}, {30'h30000, 16'd1});

    // reset mid-sweep, then a clean sweep
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst", {busy, vld, dir, 30'(step), 16'(loops)}, {3'b001, 30'h0, 16'd0});
    cfg(30'h10000, 30'h40000, 30'h10000, 32'd2, 2'd0, 16'd0);
    pulse_start();
    chk("post_rst_start", {busy, vld, 30'(step)}, {2'b11, 30'h10000});
    cyc(8);
    chk("post_rst_upd", {vld, 30'(step)}, {1'b1, 30'h20000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
